// File: rtl/pkg_cpu_typedefs.sv
// Shared CPU typedefs and register-file defaults.
package pkg_cpu_typedefs;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_NUM_RD     = 3;
  localparam int RF_NUM_WR     = 2;

  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;

  localparam rf_addr_t RF_ZERO_ADDR = '0;

endpackage

// File: rtl/cpu_rf_scoreboard.sv
// Busy-bit scoreboard for the register file: one bit per register (x0 never busy),
// set by reservations from decode, cleared by writeback, looked up per read port.
// Optional macro CPU_RF_BYPASS_EN: a same-cycle write hides the busy bit unless the
// same register is also being re-reserved.
module cpu_rf_scoreboard
  import pkg_cpu_typedefs::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_RD     = RF_NUM_RD,
  parameter int NUM_WR     = RF_NUM_WR
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] ra,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wa,
  input  logic [NUM_WR-1:0]                wr_act,
  input  logic                             rsv_en,
  input  logic [ADDR_WIDTH-1:0]            rsv_addr,
  output logic [NUM_RD-1:0]                rbusy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(RF_ZERO_ADDR);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // Writes clear first, then a reservation sets, so a newer producer wins.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_act[k]) busy_nxt[wa[k]] = 1'b0;
    end
    if (rsv_en && (rsv_addr != ZERO)) busy_nxt[rsv_addr] = 1'b1;
  end

  // Busy register; reset discards all outstanding reservations.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Per-port busy lookup; x0 always reads as not busy.
  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rbusy[i] = (ra[i] != ZERO) && busy[ra[i]];
`ifdef CPU_RF_BYPASS_EN
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_act[k] && (wa[k] == ra[i]) && !(rsv_en && (rsv_addr == ra[i])))
          rbusy[i] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/cpu_reg_file_mp.sv
// Multi-ported general-purpose register file with x0 hardwired to zero and a
// per-register busy scoreboard. Optional macro CPU_RF_BYPASS_EN enables
// same-cycle write-to-read forwarding (highest write port wins).
module cpu_reg_file_mp
  import pkg_cpu_typedefs::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_RD     = RF_NUM_RD,
  parameter int NUM_WR     = RF_NUM_WR
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] ra,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd,
  output logic [NUM_RD-1:0]                rbusy,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wa,
  input  logic [NUM_WR-1:0]                wen,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wd,
  input  logic                             rsv_en,
  input  logic [ADDR_WIDTH-1:0]            rsv_addr,
  output logic                             err_wr_coll
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(RF_ZERO_ADDR);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [NUM_WR-1:0]     wr_act;
  logic                  wr_coll;

  // A write port is effective only when enabled and not targeting x0.
  always_comb begin
    wr_act = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      wr_act[k] = wen[k] && (wa[k] != ZERO);
    end
  end

  // Two effective ports hitting the same register is a collision.
  always_comb begin
    wr_coll = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        if (wr_act[j] && wr_act[k] && (wa[j] == wa[k])) wr_coll = 1'b1;
      end
    end
  end

  // Data array update; later ports overwrite earlier ones so the highest index wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_act[k]) mem[wa[k]] <= wd[k];
      end
    end
  end

  // Collision flag registered so it pulses in the cycle after the offending writes.
  always_ff @(posedge clk) begin
    if (rst) err_wr_coll <= 1'b0;
    else     err_wr_coll <= wr_coll;
  end

  // Combinational read ports with optional forwarding; x0 always reads zero.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd[i] = mem[ra[i]];
`ifdef CPU_RF_BYPASS_EN
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_act[k] && (wa[k] == ra[i])) rd[i] = wd[k];
      end
`endif
      if (ra[i] == ZERO) rd[i] = '0;
    end
  end

  cpu_rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD),
    .NUM_WR     (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .ra       (ra),
    .wa       (wa),
    .wr_act   (wr_act),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rbusy    (rbusy)
  );

endmodule

// File: tb/tb_cpu_reg_file_mp.sv
// Testbench for cpu_reg_file_mp: directed scenarios plus random traffic, checked
// through an expectation queue against a behavioural register-file model.
// Honours CPU_RF_BYPASS_EN in the reference model when defined.
module tb_cpu_reg_file_mp;
  import pkg_cpu_typedefs::*;

  localparam int NR = RF_NUM_RD;
  localparam int NW = RF_NUM_WR;
  localparam int NREG = 2**RF_ADDR_WIDTH;

  logic clk;
  logic rst;
  logic [NR-1:0][RF_ADDR_WIDTH-1:0] ra;
  logic [NR-1:0][RF_DATA_WIDTH-1:0] rd;
  logic [NR-1:0]                    rbusy;
  logic [NW-1:0][RF_ADDR_WIDTH-1:0] wa;
  logic [NW-1:0]                    wen;
  logic [NW-1:0][RF_DATA_WIDTH-1:0] wd;
  logic                             rsv_en;
  logic [RF_ADDR_WIDTH-1:0]         rsv_addr;
  logic                             err_wr_coll;

  cpu_reg_file_mp dut (
    .clk         (clk),
    .rst         (rst),
    .ra          (ra),
    .rd          (rd),
    .rbusy       (rbusy),
    .wa          (wa),
    .wen         (wen),
    .wd          (wd),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .err_wr_coll (err_wr_coll)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [NR-1:0][RF_DATA_WIDTH-1:0] rd;
    logic [NR-1:0]                    rbusy;
    logic                             err;
    int                               cyc;
  } expect_t;

  expect_t exp_q[$];

  // Reference state: what the register file should hold after each edge
  rf_data_t ref_val  [NREG];
  bit       ref_busy [NREG];
  bit       ref_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Stimulus staging for the next cycle
  logic                             s_rst;
  logic [NR-1:0][RF_ADDR_WIDTH-1:0] s_ra;
  logic [NW-1:0][RF_ADDR_WIDTH-1:0] s_wa;
  logic [NW-1:0]                    s_wen;
  logic [NW-1:0][RF_DATA_WIDTH-1:0] s_wd;
  logic                             s_rsv_en;
  logic [RF_ADDR_WIDTH-1:0]         s_rsv_addr;

  task automatic clearStim();
    s_rst = 1'b0; s_ra = '0; s_wa = '0; s_wen = '0; s_wd = '0;
    s_rsv_en = 1'b0; s_rsv_addr = '0;
  endtask

  task automatic readAll(input int a);
    for (int i = 0; i < NR; i++) s_ra[i] = RF_ADDR_WIDTH'(a);
  endtask

  // Drive one cycle, queue what the outputs must be, then advance the model.
  task automatic applyStimulus();
    expect_t e;
    int a;
    bit fw, coll;
    rst = s_rst; ra = s_ra; wa = s_wa; wen = s_wen; wd = s_wd;
    rsv_en = s_rsv_en; rsv_addr = s_rsv_addr;

    for (int i = 0; i < NR; i++) begin
      a = int'(s_ra[i]);
      e.rd[i]    = (a == 0) ? '0 : ref_val[a];
      e.rbusy[i] = (a == 0) ? 1'b0 : ref_busy[a];
      fw = 0;
`ifdef CPU_RF_BYPASS_EN
      for (int k = 0; k < NW; k++) begin
        if (s_wen[k] && a != 0 && int'(s_wa[k]) == a) begin
          e.rd[i] = s_wd[k];
          fw = 1;
        end
      end
      if (fw && !(s_rsv_en && int'(s_rsv_addr) == a)) e.rbusy[i] = 1'b0;
`endif
    end
    e.err = ref_err;
    e.cyc = cyc;
    exp_q.push_back(e);

    if (s_rst) begin
      for (int r = 0; r < NREG; r++) begin
        ref_val[r] = '0;
        ref_busy[r] = 0;
      end
      ref_err = 0;
    end else begin
      coll = 0;
      for (int j = 0; j < NW; j++)
        for (int k = j + 1; k < NW; k++)
          if (s_wen[j] && s_wen[k] && s_wa[j] == s_wa[k] && s_wa[j] != RF_ZERO_ADDR) coll = 1;
      for (int k = 0; k < NW; k++) begin
        if (s_wen[k] && s_wa[k] != RF_ZERO_ADDR) begin
          ref_val[int'(s_wa[k])]  = s_wd[k];
          ref_busy[int'(s_wa[k])] = 0;
        end
      end
      if (s_rsv_en && s_rsv_addr != RF_ZERO_ADDR) ref_busy[int'(s_rsv_addr)] = 1;
      ref_err = coll;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input expect_t e);
    for (int i = 0; i < NR; i++) begin
      total++;
      if (rd[i] !== e.rd[i]) begin
        bad++;
        $display("[TB] FAIL rd[%0d] cycle %0d: got %h expected %h", i, e.cyc, rd[i], e.rd[i]);
      end
      total++;
      if (rbusy[i] !== e.rbusy[i]) begin
        bad++;
        $display("[TB] FAIL rbusy[%0d] cycle %0d: got %b expected %b", i, e.cyc, rbusy[i], e.rbusy[i]);
      end
    end
    total++;
    if (err_wr_coll !== e.err) begin
      bad++;
      $display("[TB] FAIL err_wr_coll cycle %0d: got %b expected %b", e.cyc, err_wr_coll, e.err);
    end
  endtask

  // Monitor: mid-cycle, compare outputs against the oldest queued expectation.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearStim();
    rst = 1'b1; ra = '0; wa = '0; wen = '0; wd = '0; rsv_en = 1'b0; rsv_addr = '0;
    for (int r = 0; r < NREG; r++) begin
      ref_val[r] = '0;
      ref_busy[r] = 0;
    end
    ref_err = 0;
    @(posedge clk);
    #1;

    $display("[TB] reset state");
    clearStim(); s_rst = 1'b1; s_ra[0] = 5'd5; s_ra[1] = 5'd9; s_ra[2] = 5'd31;
    applyStimulus();

    $display("[TB] write DEADBEEF to x5");
    clearStim(); s_wen = 2'b01; s_wa[0] = 5'd5; s_wd[0] = 32'hDEAD_BEEF; readAll(5);
    applyStimulus();
    clearStim(); readAll(5); applyStimulus();
    clearStim(); readAll(0); applyStimulus();

    $display("[TB] write to x0 ignored");
    clearStim(); s_wen = 2'b01; s_wa[0] = 5'd0; s_wd[0] = 32'h1111_1111; readAll(0);
    applyStimulus();
    clearStim(); readAll(0); applyStimulus();

    $display("[TB] same-address collision on x7");
    clearStim(); s_wen = 2'b11; s_wa[0] = 5'd7; s_wd[0] = 32'hA; s_wa[1] = 5'd7; s_wd[1] = 32'hB;
    readAll(7); applyStimulus();
    clearStim(); readAll(7); applyStimulus();
    clearStim(); readAll(7); applyStimulus();

    $display("[TB] reserve and clear x9");
    clearStim(); s_rsv_en = 1'b1; s_rsv_addr = 5'd9; readAll(9); applyStimulus();
    clearStim(); s_wen = 2'b10; s_wa[1] = 5'd9; s_wd[1] = 32'h99; readAll(9); applyStimulus();
    clearStim(); readAll(9); applyStimulus();
    clearStim(); s_rsv_en = 1'b1; s_rsv_addr = 5'd9; s_wen = 2'b01; s_wa[0] = 5'd9;
    s_wd[0] = 32'h9A; readAll(9); applyStimulus();
    clearStim(); readAll(9); applyStimulus();
    clearStim(); s_rsv_en = 1'b1; s_rsv_addr = 5'd0; readAll(0); applyStimulus();

    $display("[TB] same-cycle write and read of x3");
    clearStim(); s_wen = 2'b01; s_wa[0] = 5'd3; s_wd[0] = 32'h55; readAll(3); applyStimulus();
    clearStim(); readAll(3); applyStimulus();

    $display("[TB] reset discards state on x4");
    clearStim(); s_rsv_en = 1'b1; s_rsv_addr = 5'd4; s_wen = 2'b01; s_wa[0] = 5'd4;
    s_wd[0] = 32'h77; readAll(4); applyStimulus();
    clearStim(); s_rst = 1'b1; s_wen = 2'b11; s_wa[0] = 5'd6; s_wa[1] = 5'd6;
    s_rsv_en = 1'b1; s_rsv_addr = 5'd4; readAll(4); applyStimulus();
    clearStim(); readAll(4); s_ra[2] = 5'd6; applyStimulus();

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      clearStim();
      s_rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NR; i++)
        s_ra[i] = ($urandom_range(0, 1) == 0) ? RF_ADDR_WIDTH'($urandom_range(0, 7))
                                               : RF_ADDR_WIDTH'($urandom);
      for (int k = 0; k < NW; k++) begin
        s_wen[k] = ($urandom_range(0, 2) != 0);
        s_wa[k]  = RF_ADDR_WIDTH'($urandom_range(0, 7));
        s_wd[k]  = $urandom;
      end
      s_rsv_en   = ($urandom_range(0, 2) == 0);
      s_rsv_addr = RF_ADDR_WIDTH'($urandom_range(0, 7));
      applyStimulus();
    end

    clearStim();
    rst = 1'b0; wen = '0; rsv_en = 1'b0;
    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_reg_file_mp.md
# cpu_reg_file_mp

Multi-ported, scoreboarded general-purpose register file for the next-generation CPU core. It provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with x0 hardwired to zero. Per-register busy tracking lets the pipeline hold off on operands whose producing instruction has not yet written back. It replaces the single-write, dual-read bank in the CPU datapath and sits between decode (reads and reservations) and writeback (writes).

## Interface
- ADDR_WIDTH, 5, register address width; the file holds 2**ADDR_WIDTH entries, entry 0 hardwired to zero.
- DATA_WIDTH, 32, register width.
- NUM_RD, 3, number of read ports (≥1).
- NUM_WR, 2, number of write ports (≥1).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- ra  in  [NUM_RD-1:0][ADDR_WIDTH-1:0]  read addresses.
- rd  out  [NUM_RD-1:0][DATA_WIDTH-1:0]  read data.
- rbusy  out  [NUM_RD-1:0]  addressed register has a pending reservation.
- wa  in  [NUM_WR-1:0][ADDR_WIDTH-1:0]  write addresses.
- wen  in  [NUM_WR-1:0]  write enables.
- wd  in  [NUM_WR-1:0][DATA_WIDTH-1:0]  write data.
- rsv_en  in  1  reserve request: mark a destination as busy.
- rsv_addr  in  [ADDR_WIDTH-1:0]  register to reserve.
- err_wr_coll  out  1  registered one-cycle pulse when two enabled write ports target the same non-zero address.

## Operation
- Storage: entries 1..2**ADDR_WIDTH-1; busy bits for the same range.
- Read: rd[i] = 0 when ra[i]==0, otherwise the stored value. rbusy[i] = 0 when ra[i]==0, otherwise busy[ra[i]].
- Write: for each port k with wen[k]=1 and wa[k]≠0, the entry takes wd[k] at the next edge. Writes to address 0 are ignored.
- Same-address write collision: the highest-index port wins. err_wr_coll is asserted on the following cycle for exactly one cycle.
- Busy clear: any write (wen[k]=1, wa[k]≠0) clears busy[wa[k]] at the edge.
- Busy set: rsv_en=1 with rsv_addr≠0 sets busy[rsv_addr] at the edge. Reservation of address 0 is ignored.
- Simultaneous write and reserve to the same address: the reservation wins and busy stays 1, because a newer producer is in flight. The data write still occurs.
- Reserve of an already-busy register: busy stays 1. No counting; single outstanding producer per register.
- rst=1: all entries, all busy bits and err_wr_coll go to 0 at the next edge. This overrides any write or reserve in the same cycle. Reset mid-pipeline discards all reservations.

## Timing
- Read latency: combinational, zero cycles.
- Write latency: one edge. Without bypass, the value is visible on rd in the cycle after wen.
- Busy latency: set or clear takes effect one edge after the request.
- Outputs after reset: rd=0, rbusy=0, err_wr_coll=0.

## Configuration
- CPU_RF_BYPASS_EN defined: write-to-read forwarding is enabled.
  - If ra[i] matches an enabled non-zero wa[k] in the same cycle, rd[i] returns wd[k]; with multiple matches, the highest k wins.
  - rbusy[i] reads 0 for that address unless rsv_en targets it in the same cycle.
- CPU_RF_BYPASS_EN undefined: reads return stored state only, and rbusy reflects registered busy bits only.

## Structure
- pkg_cpu_typedefs gains:
  - rf_addr_t and rf_data_t typedefs.
  - RF_ZERO_ADDR constant (0).
  - Default RF_NUM_RD and RF_NUM_WR constants, used as the module's parameter defaults.
- One sub-module, cpu_rf_scoreboard, holds the busy-bit array together with its set/clear/reset logic and the rbusy lookup. The data array, write-priority logic and bypass mux stay in the top module.

## Test plan
- Reset, then write 32'hDEAD_BEEF to x5 on port 0. Read x5 on all read ports the next cycle → all return 32'hDEAD_BEEF. Reading x0 → 0.
- Write 32'h1111_1111 to x0 → any read of x0 returns 0, and no busy bit is set.
- Same cycle, port 0 writes 32'hA to x7 and port 1 writes 32'hB to x7 → x7 reads 32'hB. err_wr_coll=1 for exactly one cycle, then 0.
- Reserve x9 → rbusy=1 from the next cycle. A write to x9 clears it on the following edge. A write and reserve to x9 in the same cycle → busy stays 1.
- With CPU_RF_BYPASS_EN defined: write 32'h55 to x3 while reading x3 in the same cycle → rd=32'h55 and rbusy=0. Without the macro → rd returns the old value (0).
- Reserve x4 and write x4=32'h77, then assert rst for one cycle → x4 reads 0, rbusy=0, err_wr_coll=0.
